// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps a 3-input function block through all 8 vectors and checks it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        sweep request (honoured in IDLE only), sweep cancel
//   exp_f1..exp_f3      expected truth tables, bit i = expected output at vector i
//   f1..f3              outputs of the function block under test
//   a, b, c             registered vector drive, {a,b,c} = vector index
//   busy, done, pass    sweep active, one-cycle completion pulse, last sweep clean
//   tt_f1..tt_f3        captured truth tables
//   err_mask            per-vector mismatch flags
//   err_count           number of mismatching vectors
//   first_fail          lowest mismatching vector index, 0 when none
module truth_table_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] exp_f1,
   input  logic [7:0] exp_f2,
   input  logic [7:0] exp_f3,
   input  logic       f1,
   input  logic       f2,
   input  logic       f3,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] tt_f1,
   output logic [7:0] tt_f2,
   output logic [7:0] tt_f3,
   output logic [7:0] err_mask,
   output logic [3:0] err_count,
   output logic [2:0] first_fail
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
   localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
   state_t     state, state_n;
   logic [2:0] idx, idx_n, first_fail_n;
   logic [3:0] cnt, cnt_n, err_count_n;
   logic [7:0] tt_f1_n, tt_f2_n, tt_f3_n, err_mask_n;
   logic       done_n, pass_n, mism;
   assign {a, b, c} = idx;
   assign busy = state != IDLE;
   assign mism = |({f1, f2, f3} ^ {exp_f1[idx], exp_f2[idx], exp_f3[idx]});
   always_comb begin
      state_n      = state;
      idx_n        = idx;
      cnt_n        = cnt;
      done_n       = 1'b0;
      pass_n       = pass;
      tt_f1_n      = tt_f1;
      tt_f2_n      = tt_f2;
      tt_f3_n      = tt_f3;
      err_mask_n   = err_mask;
      err_count_n  = err_count;
      first_fail_n = first_fail;
      case (state)
         IDLE: if (start && !abort) begin
            state_n      = SETTLE;
            idx_n        = 3'd0;
            cnt_n        = SC;
            pass_n       = 1'b0;
            tt_f1_n      = 8'h00;
            tt_f2_n      = 8'h00;
            tt_f3_n      = 8'h00;
            err_mask_n   = 8'h00;
            err_count_n  = 4'd0;
            first_fail_n = 3'd0;
         end
         SETTLE: if (abort) begin
            state_n = IDLE;
            idx_n   = 3'd0;
            pass_n  = 1'b0;
         end else begin
            cnt_n   = cnt - 4'd1;
            state_n = cnt == 4'd1 ? SAMPLE : SETTLE;
         end
         SAMPLE: if (abort) begin
            state_n = IDLE;
            idx_n   = 3'd0;
            pass_n  = 1'b0;
         end else begin
            tt_f1_n[idx]    = f1;
            tt_f2_n[idx]    = f2;
            tt_f3_n[idx]    = f3;
            err_mask_n[idx] = mism;
            err_count_n     = err_count + {3'd0, mism};
            // err_count still zero means this is the sweep's first mismatch
            first_fail_n    = mism && err_count == 4'd0 ? idx : first_fail;
            if (idx == 3'd7) begin
               state_n = IDLE;
               idx_n   = 3'd0;
               cnt_n   = 4'd0;
               done_n  = 1'b1;
               pass_n  = err_count_n == 4'd0;
            end else begin
               state_n = SETTLE;
               idx_n   = idx + 3'd1;
               cnt_n   = SC;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= 3'd0;
         cnt        <= 4'd0;
         done       <= 1'b0;
         pass       <= 1'b0;
         tt_f1      <= 8'h00;
         tt_f2      <= 8'h00;
         tt_f3      <= 8'h00;
         err_mask   <= 8'h00;
         err_count  <= 4'd0;
         first_fail <= 3'd0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         done       <= done_n;
         pass       <= pass_n;
         tt_f1      <= tt_f1_n;
         tt_f2      <= tt_f2_n;
         tt_f3      <= tt_f3_n;
         err_mask   <= err_mask_n;
         err_count  <= err_count_n;
         first_fail <= first_fail_n;
      end
   end
endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning wait cycles after each input vector is applied before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  sweep request, sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  synchronous sweep cancel.
REQ-006 SHALL have port exp_f1, exp_f2, exp_f3  input  8 each  expected truth tables; bit i = expected output for vector index i.
REQ-007 SHALL have port f1, f2, f3  input  1 each  outputs of the combinational function block under control.
REQ-008 SHALL have port a, b, c  output  1 each  registered drive to the function block; {a,b,c} = vector index, a = MSB.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 SHALL have port tt_f1, tt_f2, tt_f3  output  8 each  captured truth tables; bit i = sampled output at vector i.
REQ-013 SHALL have port err_mask  output  8  bit i set if any of f1..f3 mismatched at vector i.
REQ-014 SHALL have port err_count  output  4  number of mismatching vectors, 0..8.
REQ-015 SHALL have port first_fail  output  3  lowest mismatching vector index; 0 when none.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE.
REQ-017 IDLE with start=1 and abort=0 SHALL, at that edge, clear tt_*, err_mask, err_count, first_fail and pass; set {a,b,c}=000, idx=0, busy=1, settle counter=SETTLE_CYCLES; then go to SETTLE.
REQ-018 SETTLE SHALL decrement the counter each cycle and go to SAMPLE on the edge where the counter reaches 0.
REQ-019 SAMPLE SHALL last one cycle: on its edge, write f1/f2/f3 into tt_* bit idx; set err_mask[idx] = |({f1,f2,f3} ^ {exp_f1[idx],exp_f2[idx],exp_f3[idx]}); on mismatch, increment err_count and, if this is the first mismatch of the sweep, load first_fail=idx.
REQ-020 SAMPLE with idx<7 SHALL increment idx, update {a,b,c} on the same edge, reload the counter and return to SETTLE.
REQ-021 SAMPLE with idx=7 SHALL go to IDLE, drive {a,b,c}=000, busy=0 and done=1 for exactly one cycle, and set pass=1 if the final err_count is 0, counting vector 7.
REQ-022 Each vector SHALL occupy SETTLE_CYCLES+1 cycles; done SHALL rise 8*(SETTLE_CYCLES+1) cycles after the start-accept edge (24 at default).
REQ-023 Results (tt_*, err_*, first_fail, pass) SHALL hold until the next accepted start or reset.
REQ-024 start while busy SHALL be ignored; exp_* SHALL be sampled live at each SAMPLE edge.
REQ-025 abort=1 in SETTLE or SAMPLE SHALL, at that edge, go to IDLE with busy=0, {a,b,c}=000, no done pulse and pass=0; partial tt_*/err_* SHALL be retained; no SAMPLE update occurs on that edge.
REQ-026 abort=1 with start=1 in IDLE SHALL take precedence: start ignored, no state change.

Reset
REQ-027 rst=1 SHALL, at any edge including mid-sweep, force IDLE; a=b=c=0, busy=0, done=0, pass=0, tt_*=0, err_mask=0, err_count=0, first_fail=0, idx=0, counter=0. rst SHALL override start and abort.

Verification
REQ-028 Clean sweep: exp_f1=8'hEA, f1 modelled as (a&b)|c, f2/f3 match their exp -> done at cycle 24, tt_f1=8'hEA, pass=1, err_count=0, err_mask=0.
REQ-029 Injected faults: f2 inverted at vectors 3 and 5 only -> err_mask=8'h28, err_count=2, first_fail=3, pass=0.
REQ-030 Waveform: {a,b,c} steps 000..111, each held 3 cycles; busy high for exactly 24 cycles; done high for exactly one cycle.
REQ-031 start pulsed again at cycle 10 of a sweep -> ignored, done still at cycle 24; start the cycle after done -> new sweep clears results.
REQ-032 abort at vector 4 -> busy=0 next cycle, no done, pass=0, tt_* bits 0..3 retained; rst at vector 6 -> all outputs at reset values.
REQ-033 SETTLE_CYCLES=1 -> done at cycle 16; vector hold 2 cycles.
